inst_prefetch: RTL and testbench
================================

INST_PREFETCH -- requirements
Module: inst_prefetch

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the prefetch queue entry count (power of two, 2..8).
REQ-002 Parameter RESET_PC, default 32'h0000_0000, SHALL set the first fetch address after reset.
REQ-003 Port clk  input  1  SHALL be the single clock; all state updates on the rising edge.
REQ-004 Port rst  input  1  SHALL be the asynchronous, active-low reset (0 = reset).
REQ-005 Port imem_req  output  1  SHALL be the instruction ROM read strobe.
REQ-006 Port imem_addr  output  6  SHALL be the ROM word address, equal to fetch_pc[7:2].
REQ-007 Port imem_data  input  32  SHALL be the ROM word, valid exactly one cycle after imem_req.
REQ-008 Port redirect  input  1  SHALL be the branch/jump/jr taken pulse from the controller.
REQ-009 Port redirect_pc  input  32  SHALL be the new target, sampled when redirect=1.
REQ-010 Port halt  input  1  SHALL be the fetch hold request.
REQ-011 Port inst_valid  output  1  SHALL flag that inst_code/inst_pc_plus4 hold a queued instruction.
REQ-012 Port inst_ready  input  1  SHALL be the decode-stage acceptance signal.
REQ-013 Port inst_code  output  32  SHALL be the head-of-queue instruction word.
REQ-014 Port inst_pc_plus4  output  32  SHALL be the head instruction's address + 4 (the PC_new value).

Function
REQ-015 The FSM SHALL have states BOOT, RUN and HOLD; reset enters BOOT, BOOT->RUN unconditionally after one cycle, RUN->HOLD when halt=1, HOLD->RUN when halt=0.
REQ-016 In RUN, imem_req SHALL be 1 iff count + inflight < DEPTH; it SHALL be 0 in BOOT and HOLD.
REQ-017 Each issued request SHALL advance fetch_pc by 4, wrapping modulo 2^32.
REQ-018 The response cycle SHALL push {imem_data, request address + 4} into the queue; the queue output SHALL be registered, never bypassed.
REQ-019 A pop SHALL occur iff inst_valid=1 and inst_ready=1; inst_valid SHALL equal (count != 0).
REQ-020 A simultaneous push and pop SHALL leave count unchanged; read and write pointers SHALL wrap modulo DEPTH.
REQ-021 A push to a full queue SHALL be impossible by construction (REQ-016); an assertion SHALL check it.
REQ-022 On redirect=1: the pop handshake in that same cycle SHALL complete normally; the queue SHALL then be flushed (count=0, pointers=0); fetch_pc SHALL load {redirect_pc[31:2], 2'b00}; any in-flight response SHALL be discarded.
REQ-023 The first request to the redirect target SHALL issue in the cycle after redirect; inst_valid SHALL remain 0 for at least two cycles after redirect.
REQ-024 Redirect SHALL take priority over halt for the fetch_pc update; in HOLD, the queue SHALL still drain and in-flight responses SHALL still be pushed.
REQ-025 Back-to-back redirects SHALL each be honoured; the last one wins.
REQ-026 With inst_ready held at 1 and no redirect, steady-state throughput SHALL be one instruction per cycle.

Reset
REQ-027 While rst=0: state=BOOT, fetch_pc=RESET_PC, count=0, pointers=0, inflight=0, imem_req=0, imem_addr=RESET_PC[7:2], inst_valid=0, inst_code=0, inst_pc_plus4=0.
REQ-028 Reset asserted mid-operation SHALL discard all queued and in-flight instructions immediately and asynchronously.
REQ-029 The first imem_req SHALL occur in the second cycle after rst deasserts; the first inst_valid=1 SHALL occur two cycles after that.

Structure
REQ-030 The FSM state encoding, RESET_PC default and the constant 32'd4 SHALL reside in the shared package cpu_pkg.
REQ-031 The queue SHALL be a separate sub-module, prefetch_fifo (parameterised on DEPTH and width 64, with flush input).
REQ-032 All other logic SHALL reside in inst_prefetch; no multi-driven nets and no latches.

Verification
REQ-033 Reset release, ROM[0..3]=A,B,C,D, inst_ready=1 -> inst_code A,B,C,D on consecutive cycles, inst_pc_plus4 = 4,8,12,16.
REQ-034 inst_ready=0 for 10 cycles -> imem_req drops once count+inflight=4; on ready=1, 4 buffered words emerge in order, none lost or duplicated.
REQ-035 redirect=1, redirect_pc=32'h0000_0023 while queue holds 3 entries -> queue flushed, next imem_addr=6'd8, next inst_pc_plus4=32'h24.
REQ-036 redirect together with a pop in the same cycle -> popped word delivered exactly once; no stale word after the redirect.
REQ-037 halt=1 for 5 cycles with ready=1 -> imem_req=0, queue drains to inst_valid=0; on halt=0 fetch resumes at the next sequential address.
REQ-038 rst=0 asserted mid-stream -> all outputs reach REQ-027 values in the same cycle; restart from RESET_PC.

Source files
------------

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared fetch-stage definitions: FSM encoding, reset PC and
//                the PC increment used by the instruction prefetcher.
//  Revision    : 1.0  initial release
// ============================================================================
package cpu_pkg;

  // Fetch controller states
  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_INCR          = 32'd4;

  // One queued instruction: word in the upper half, its PC+4 in the lower
  typedef struct packed {
    logic [31:0] code;
    logic [31:0] pc_plus4;
  } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/prefetch_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : prefetch_fifo
//  Description : Power-of-two circular queue with synchronous flush. The read
//                port shows the stored head entry only (no write bypass) and
//                reads as zero while empty.
//  Revision    : 1.0  initial release
// ============================================================================
module prefetch_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 64,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             valid,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;
  logic             do_pop;

  assign valid  = (count != '0);
  assign full   = (count == CNT_W'(DEPTH));
  assign do_pop = pop && valid;
  assign rdata  = valid ? mem[rd_ptr] : '0;

  // Pointer and occupancy bookkeeping; flush wins over any push/pop
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents need no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= wdata;
  end

  // The producer throttles itself on occupancy, so a full push is a bug
  a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst) !(push && full));

endmodule
`default_nettype wire

// File: rtl/inst_prefetch.sv
`default_nettype none
// ============================================================================
//  Module      : inst_prefetch
//  Description : Instruction prefetcher. Streams sequential ROM reads into a
//                small queue, presents the head to decode with a valid/ready
//                handshake, and restarts on redirect or holds on halt.
//  Revision    : 1.0  initial release
// ============================================================================
module inst_prefetch
  import cpu_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [5:0]  imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_code,
  output logic [31:0] inst_pc_plus4
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  fetch_state_t     state;
  fetch_state_t     state_next;
  logic [31:0]      fetch_pc;
  logic [31:0]      inflight_pc4;
  logic             inflight;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] occupancy;
  logic             pop;
  fetch_entry_t     push_entry;
  fetch_entry_t     head_entry;

  // Outstanding ROM read counts against capacity so a response always fits
  assign occupancy = count + CNT_W'(inflight);
  assign imem_addr = fetch_pc[7:2];
  assign pop       = inst_valid && inst_ready;

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_BOOT;
    else      state <= state_next;
  end

  // Next-state and read-strobe decode
  always_comb begin
    state_next = state;
    imem_req   = 1'b0;
    case (state)
      ST_BOOT: state_next = ST_RUN;
      ST_RUN: begin
        imem_req = (occupancy < CNT_W'(DEPTH));
        if (halt) state_next = ST_HOLD;
      end
      ST_HOLD: begin
        if (!halt) state_next = ST_RUN;
      end
      default: state_next = ST_BOOT;
    endcase
  end

  // Fetch PC and in-flight tracking; a redirect kills any read still out
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc     <= RESET_PC;
      inflight     <= 1'b0;
      inflight_pc4 <= '0;
    end else begin
      if (redirect)      fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
      else if (imem_req) fetch_pc <= fetch_pc + PC_INCR;
      inflight <= imem_req && !redirect;
      if (imem_req) inflight_pc4 <= fetch_pc + PC_INCR;
    end
  end

  assign push_entry.code     = imem_data;
  assign push_entry.pc_plus4 = inflight_pc4;

  prefetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (64)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect),
    .push  (inflight),
    .wdata (push_entry),
    .pop   (pop),
    .rdata (head_entry),
    .valid (inst_valid),
    .count (count)
  );

  assign inst_code     = head_entry.code;
  assign inst_pc_plus4 = head_entry.pc_plus4;

endmodule
`default_nettype wire

// File: tb/tb_inst_prefetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_inst_prefetch
//  Description : Directed self-checking bench for inst_prefetch with a
//                one-cycle-latency ROM whose word at address a is BASE|a.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_inst_prefetch;

  localparam logic [31:0] ROM_BASE = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [5:0]  imem_addr;
  logic [31:0] imem_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_code;
  logic [31:0] inst_pc_plus4;

  int num_checks = 0;
  int num_errors = 0;

  always #5 clk = ~clk;

  inst_prefetch #(
    .DEPTH    (4),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .halt          (halt),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .inst_code     (inst_code),
    .inst_pc_plus4 (inst_pc_plus4)
  );

  function automatic logic [31:0] rom_word(input logic [5:0] a);
    return ROM_BASE | {26'd0, a};
  endfunction

  // ROM: data one cycle after the strobe, garbage otherwise
  always @(posedge clk) imem_data <= imem_req ? rom_word(imem_addr) : 32'hBAD0_0000;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    num_checks++;
    if (actual !== expected) begin
      num_errors++;
      $display("FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  task automatic expect_head(input string tag, input logic [5:0] word, input logic [31:0] pc4);
    check({tag, "_valid"}, {31'd0, inst_valid}, 32'd1);
    check({tag, "_code"},  inst_code, rom_word(word));
    check({tag, "_pc4"},   inst_pc_plus4, pc4);
  endtask

  initial begin
    rst         = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'd0;
    halt        = 1'b0;
    inst_ready  = 1'b1;
    tick;
    tick;
    check("rst_req",   {31'd0, imem_req},   32'd0);
    check("rst_addr",  {26'd0, imem_addr},  32'd0);
    check("rst_valid", {31'd0, inst_valid}, 32'd0);
    check("rst_code",  inst_code,           32'd0);
    check("rst_pc4",   inst_pc_plus4,       32'd0);

    // Release: BOOT cycle, first request next cycle, first valid two later
    rst = 1'b1;
    check("boot_req", {31'd0, imem_req}, 32'd0);
    tick;
    check("c1_req",   {31'd0, imem_req},   32'd1);
    check("c1_addr",  {26'd0, imem_addr},  32'd0);
    check("c1_valid", {31'd0, inst_valid}, 32'd0);
    tick;
    check("c2_addr",  {26'd0, imem_addr},  32'd1);
    check("c2_valid", {31'd0, inst_valid}, 32'd0);
    tick; expect_head("seq_A", 6'd0, 32'd4);
    tick; expect_head("seq_B", 6'd1, 32'd8);
    tick; expect_head("seq_C", 6'd2, 32'd12);
    tick; expect_head("seq_D", 6'd3, 32'd16);

    // Back-pressure: queue fills to 4 and fetch stops
    inst_ready = 1'b0;
    repeat (3) tick;
    check("stall_req_a", {31'd0, imem_req}, 32'd0);
    expect_head("stall_head_a", 6'd3, 32'd16);
    repeat (6) tick;
    check("stall_req_b", {31'd0, imem_req}, 32'd0);
    expect_head("stall_head_b", 6'd3, 32'd16);
    inst_ready = 1'b1;
    tick; expect_head("drain_4", 6'd4, 32'd20);
    tick; expect_head("drain_5", 6'd5, 32'd24);
    tick; expect_head("drain_6", 6'd6, 32'd28);
    tick; expect_head("drain_7", 6'd7, 32'd32);
    tick; expect_head("drain_8", 6'd8, 32'd36);

    // Build 3 queued entries, then redirect while popping the head
    inst_ready = 1'b0;
    tick;
    check("pre_redir_req", {31'd0, imem_req}, 32'd0);
    expect_head("pre_redir_head", 6'd8, 32'd36);
    inst_ready  = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0023;
    tick;
    redirect = 1'b0;
    check("redir_valid_1", {31'd0, inst_valid}, 32'd0);
    check("redir_req",     {31'd0, imem_req},   32'd1);
    check("redir_addr",    {26'd0, imem_addr},  32'd8);
    tick;
    check("redir_valid_2", {31'd0, inst_valid}, 32'd0);
    check("redir_addr_2",  {26'd0, imem_addr},  32'd9);
    tick; expect_head("redir_first",  6'd8, 32'h24);
    tick; expect_head("redir_second", 6'd9, 32'h28);

    // Halt for five cycles: fetch stops, queue drains, then resumes
    halt = 1'b1;
    tick;
    check("halt_req_1", {31'd0, imem_req}, 32'd0);
    expect_head("halt_h10", 6'd10, 32'h2C);
    tick; expect_head("halt_h11", 6'd11, 32'h30);
    tick;
    check("halt_empty_1", {31'd0, inst_valid}, 32'd0);
    check("halt_req_2",   {31'd0, imem_req},   32'd0);
    tick;
    check("halt_empty_2", {31'd0, inst_valid}, 32'd0);
    tick;
    check("halt_req_3", {31'd0, imem_req}, 32'd0);
    halt = 1'b0;
    tick;
    check("resume_req",  {31'd0, imem_req},  32'd1);
    check("resume_addr", {26'd0, imem_addr}, 32'd12);
    tick;
    check("resume_valid0", {31'd0, inst_valid}, 32'd0);
    tick; expect_head("resume_h12", 6'd12, 32'h34);

    // Asynchronous reset mid-stream
    tick;
    rst = 1'b0;
    #1;
    check("mrst_req",   {31'd0, imem_req},   32'd0);
    check("mrst_addr",  {26'd0, imem_addr},  32'd0);
    check("mrst_valid", {31'd0, inst_valid}, 32'd0);
    check("mrst_code",  inst_code,           32'd0);
    check("mrst_pc4",   inst_pc_plus4,       32'd0);
    tick;
    rst = 1'b1;
    tick;
    check("restart_req",  {31'd0, imem_req},  32'd1);
    check("restart_addr", {26'd0, imem_addr}, 32'd0);
    tick;
    tick; expect_head("restart_A", 6'd0, 32'd4);

    // Back-to-back redirects: the second target wins
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0040;
    tick;
    redirect_pc = 32'h0000_0080;
    check("b2b_valid_1", {31'd0, inst_valid}, 32'd0);
    tick;
    redirect = 1'b0;
    check("b2b_req",     {31'd0, imem_req},   32'd1);
    check("b2b_addr",    {26'd0, imem_addr},  32'd32);
    check("b2b_valid_2", {31'd0, inst_valid}, 32'd0);
    tick;
    check("b2b_valid_3", {31'd0, inst_valid}, 32'd0);
    tick; expect_head("b2b_h32", 6'd32, 32'h84);
    tick; expect_head("b2b_h33", 6'd33, 32'h88);

    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule
`default_nettype wire
